// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared definitions for the UART receive controller: register
//           addresses, STATUS/CTRL/IE bit positions, drain FSM states, FIFO
//           entry width and the BAUD_SEL -> clocks-per-bit lookup.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Register addresses
  localparam logic [1:0] c_ADDR_DATA   = 2'd0;
  localparam logic [1:0] c_ADDR_STATUS = 2'd1;
  localparam logic [1:0] c_ADDR_CTRL   = 2'd2;
  localparam logic [1:0] c_ADDR_IE     = 2'd3;

  // STATUS bit positions
  localparam int c_ST_NOT_EMPTY = 0;
  localparam int c_ST_FULL      = 1;
  localparam int c_ST_PERR      = 2;
  localparam int c_ST_FERR      = 3;
  localparam int c_ST_ENG_OVF   = 4;
  localparam int c_ST_FIFO_OVR  = 5;
  localparam int c_ST_TIMEOUT   = 6;

  // CTRL bit positions
  localparam int c_CTRL_EIGHT   = 0;
  localparam int c_CTRL_PEN     = 1;
  localparam int c_CTRL_OHEL    = 2;
  localparam int c_CTRL_SEL_LSB = 3;
  localparam int c_CTRL_SEL_MSB = 6;

  // IE bit positions
  localparam int c_IE_DATA    = 0;
  localparam int c_IE_ERR     = 1;
  localparam int c_IE_TIMEOUT = 2;

  // CTRL reset value: EIGHT=1, PEN=0, OHEL=0, BAUD_SEL=4
  localparam logic [6:0] c_CTRL_RESET = 7'h21;

  // FIFO entry: {ferr, perr, data[7:0]}
  localparam int c_ENTRY_W = 10;
  localparam int c_BAUD_W  = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2
  } rx_state_t;

  // Rounded clocks-per-bit for a given line rate
  function automatic logic [c_BAUD_W-1:0] baud_div(input int unsigned clk_hz,
                                                   input int unsigned baud);
    return c_BAUD_W'((clk_hz + baud / 2) / baud);
  endfunction

  // BAUD_SEL lookup; unused selector codes fall back to 9600 baud
  function automatic logic [c_BAUD_W-1:0] baud_decode(input logic [3:0] sel,
                                                      input int unsigned clk_hz);
    case (sel)
      4'd0:    return baud_div(clk_hz, 300);
      4'd1:    return baud_div(clk_hz, 1200);
      4'd2:    return baud_div(clk_hz, 2400);
      4'd3:    return baud_div(clk_hz, 4800);
      4'd4:    return baud_div(clk_hz, 9600);
      4'd5:    return baud_div(clk_hz, 19200);
      4'd6:    return baud_div(clk_hz, 38400);
      4'd7:    return baud_div(clk_hz, 57600);
      4'd8:    return baud_div(clk_hz, 115200);
      4'd9:    return baud_div(clk_hz, 230400);
      4'd10:   return baud_div(clk_hz, 460800);
      4'd11:   return baud_div(clk_hz, 921600);
      default: return baud_div(clk_hz, 9600);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Purpose : Synchronous FIFO for received characters. Pop on empty is
//           ignored; push while full is accepted only when a pop happens in
//           the same cycle. Flush overrides push and pop.
// Ports   : clk, rst (async, active-high)
//           push, pop, flush, din[WIDTH]  - control and write data
//           head[WIDTH]                   - entry at the read pointer
//           full, empty                   - occupancy flags
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int             c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]  c_FULL_CNT = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_FULL_CNT);
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ctrl
// Purpose : Bus-facing controller for the UART receive engine. Holds frame
//           and baud configuration, drains characters from the engine into a
//           local FIFO, exposes DATA/STATUS/CTRL/IE registers and an IRQ.
// Config  : `define UART_RX_TIMEOUT_EN adds the 32-bit-time receive timeout
//           (STATUS[6], IE[2]); without it both read as 0.
// Ports   : clk, rst (async, active-high)
//           cs, we, addr[2], wdata[8]  - single-cycle CPU access
//           rdata[8]                   - registered read data
//           irq                        - registered level interrupt
//           eng_baud_decode[19], eng_eight, eng_pen, eng_ohel - engine config
//           eng_reads                  - one-cycle character acknowledge
//           eng_rdata[8], eng_rx_rdy, eng_perr, eng_ferr, eng_ovf - engine
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int unsigned CLK_HZ     = 100000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                we,
  input  logic [1:0]          addr,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata,
  output logic                irq,
  output logic [c_BAUD_W-1:0] eng_baud_decode,
  output logic                eng_eight,
  output logic                eng_pen,
  output logic                eng_ohel,
  output logic                eng_reads,
  input  logic [7:0]          eng_rdata,
  input  logic                eng_rx_rdy,
  input  logic                eng_perr,
  input  logic                eng_ferr,
  input  logic                eng_ovf
);

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [2:0] c_IE_MASK = 3'b111;
`else
  localparam logic [2:0] c_IE_MASK = 3'b011;
`endif

  logic [6:0]           r_ctrl;
  logic [2:0]           r_ie;
  logic                 r_eng_ovf;
  logic                 r_fifo_ovr;
  logic [7:0]           r_rdata;
  logic                 r_irq;
  rx_state_t            r_state;
  logic                 r_reads;

  logic                 w_rd;
  logic                 w_wr;
  logic                 w_rd_data;
  logic                 w_rd_status;
  logic                 w_wr_ctrl;
  logic                 w_wr_ie;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_flush;
  logic                 w_overrun;
  logic [c_ENTRY_W-1:0] w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_head_perr;
  logic                 w_head_ferr;
  logic                 w_timeout;
  logic [7:0]           w_status;
  logic                 w_unused;

  assign w_rd        = cs & ~we;
  assign w_wr        = cs & we;
  assign w_rd_data   = w_rd & (addr == c_ADDR_DATA);
  assign w_rd_status = w_rd & (addr == c_ADDR_STATUS);
  assign w_wr_ctrl   = w_wr & (addr == c_ADDR_CTRL);
  assign w_wr_ie     = w_wr & (addr == c_ADDR_IE);

  // One push per DRAIN cycle; a CTRL write flushes and discards that push
  assign w_push    = (r_state == DRAIN);
  assign w_pop     = w_rd_data & ~w_empty;
  assign w_flush   = w_wr_ctrl;
  assign w_overrun = w_push & w_full & ~w_pop & ~w_flush;

  // Head error flags only mean something while an entry is present
  assign w_head_perr = w_head[8] & ~w_empty;
  assign w_head_ferr = w_head[9] & ~w_empty;

  assign w_status = {1'b0, w_timeout, r_fifo_ovr, r_eng_ovf,
                     w_head_ferr, w_head_perr, w_full, ~w_empty};

  assign eng_baud_decode = baud_decode(r_ctrl[c_CTRL_SEL_MSB:c_CTRL_SEL_LSB], CLK_HZ);
  assign eng_eight       = r_ctrl[c_CTRL_EIGHT];
  assign eng_pen         = r_ctrl[c_CTRL_PEN];
  assign eng_ohel        = r_ctrl[c_CTRL_OHEL];
  assign eng_reads       = r_reads;
  assign rdata           = r_rdata;
  assign irq             = r_irq;

  // CTRL[7] is reserved and never stored
  assign w_unused = wdata[7];

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   ({eng_ferr, eng_perr, eng_rdata}),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Drain FSM; eng_reads is high exactly while in DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_reads <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (eng_rx_rdy) begin
            r_state <= DRAIN;
            r_reads <= 1'b1;
          end
        end
        DRAIN: begin
          r_state <= WAIT;
          r_reads <= 1'b0;
        end
        WAIT: begin
          // Hold until the engine drops ready so one character gives one push
          if (!eng_rx_rdy) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_reads <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags: a new event beats a clearing STATUS read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eng_ovf  <= 1'b0;
      r_fifo_ovr <= 1'b0;
    end else if (w_flush) begin
      r_eng_ovf  <= 1'b0;
      r_fifo_ovr <= 1'b0;
    end else begin
      if (w_push && eng_ovf) r_eng_ovf <= 1'b1;
      else if (w_rd_status)  r_eng_ovf <= 1'b0;
      if (w_overrun)         r_fifo_ovr <= 1'b1;
      else if (w_rd_status)  r_fifo_ovr <= 1'b0;
    end
  end

  // Configuration registers and registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl  <= c_CTRL_RESET;
      r_ie    <= 3'b000;
      r_rdata <= 8'h00;
    end else begin
      if (w_wr_ctrl) r_ctrl <= wdata[6:0];
      if (w_wr_ie)   r_ie   <= wdata[2:0] & c_IE_MASK;
      if (w_rd) begin
        case (addr)
          c_ADDR_DATA:   r_rdata <= w_empty ? 8'h00 : w_head[7:0];
          c_ADDR_STATUS: r_rdata <= w_status;
          c_ADDR_CTRL:   r_rdata <= {1'b0, r_ctrl};
          c_ADDR_IE:     r_rdata <= {5'b00000, r_ie};
          default:       r_rdata <= 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_ie[c_IE_DATA] & ~w_empty)
             | (r_ie[c_IE_ERR] & (r_eng_ovf | r_fifo_ovr | w_head_perr | w_head_ferr))
             | (r_ie[c_IE_TIMEOUT] & w_timeout);
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [c_BAUD_W-1:0] r_presc;
  logic [5:0]          r_bits;
  logic                r_timeout;
  logic                w_idle_clr;
  logic                w_bit_tick;

  // Any FIFO activity, or nothing to time out on, restarts the count
  assign w_idle_clr = w_push | w_pop | w_flush | w_empty;
  assign w_bit_tick = (r_presc == eng_baud_decode - c_BAUD_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_bits    <= 6'd0;
      r_timeout <= 1'b0;
    end else if (w_idle_clr) begin
      r_presc   <= '0;
      r_bits    <= 6'd0;
      r_timeout <= 1'b0;
    end else if (!r_timeout) begin
      if (w_bit_tick) begin
        r_presc <= '0;
        r_bits  <= r_bits + 6'd1;
        if (r_bits == 6'd31) r_timeout <= 1'b1;
      end else begin
        r_presc <= r_presc + c_BAUD_W'(1);
      end
    end
  end

  assign w_timeout = r_timeout;
`else
  assign w_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_ctrl
// Purpose : Directed self-checking bench for uart_rx_ctrl. A small engine
//           model presents characters; register reads are compared against
//           hand-computed values.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [1:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        irq;
  logic [18:0] eng_baud_decode;
  logic        eng_eight;
  logic        eng_pen;
  logic        eng_ohel;
  logic        eng_reads;
  logic [7:0]  eng_rdata;
  logic        eng_rx_rdy;
  logic        eng_perr;
  logic        eng_ferr;
  logic        eng_ovf;

  int checks    = 0;
  int errors    = 0;
  int reads_cnt = 0;

  uart_rx_ctrl #(
    .FIFO_DEPTH (8),
    .CLK_HZ     (100000000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cs              (cs),
    .we              (we),
    .addr            (addr),
    .wdata           (wdata),
    .rdata           (rdata),
    .irq             (irq),
    .eng_baud_decode (eng_baud_decode),
    .eng_eight       (eng_eight),
    .eng_pen         (eng_pen),
    .eng_ohel        (eng_ohel),
    .eng_reads       (eng_reads),
    .eng_rdata       (eng_rdata),
    .eng_rx_rdy      (eng_rx_rdy),
    .eng_perr        (eng_perr),
    .eng_ferr        (eng_ferr),
    .eng_ovf         (eng_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (eng_reads) reads_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = rdata;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(tag, 32'(d), exp);
  endtask

  // Engine model: present a character, wait for READS, then release
  task automatic send_char(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    int  start;
    bit  seen;
    start = reads_cnt;
    seen  = 1'b0;
    @(negedge clk);
    eng_rdata = d; eng_perr = pe; eng_ferr = fe; eng_ovf = ov; eng_rx_rdy = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (eng_reads) seen = 1'b1;
    end
    check("reads_seen", 32'(seen), 1);
    @(negedge clk);
    eng_rx_rdy = 1'b0; eng_perr = 1'b0; eng_ferr = 1'b0; eng_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reads_once", 32'(reads_cnt - start), 1);
  endtask

  initial begin
    logic [7:0] rd;
    int         n;
    bit         seen;

    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'h00;
    eng_rdata = 8'h00; eng_rx_rdy = 1'b0; eng_perr = 1'b0; eng_ferr = 1'b0; eng_ovf = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rdata", 32'(rdata), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_reads", 32'(eng_reads), 0);
    check("rst_baud", 32'(eng_baud_decode), 10417);
    check("rst_eng_bits", 32'({eng_ohel, eng_pen, eng_eight}), 'h1);
    rst = 1'b0;

    read_check("rst_ctrl", 2'd2, 'h21);
    read_check("rst_status", 2'd1, 'h00);
    read_check("rst_ie", 2'd3, 'h00);
    read_check("empty_data", 2'd0, 'h00);

    // Configuration
    bus_write(2'd2, 8'h47);
    check("baud_sel8", 32'(eng_baud_decode), 868);
    check("eng_bits_47", 32'({eng_ohel, eng_pen, eng_eight}), 'h7);
    read_check("ctrl_47", 2'd2, 'h47);
    bus_write(2'd2, 8'h01);
    check("baud_sel0", 32'(eng_baud_decode), 333333);
    bus_write(2'd2, 8'h59);
    check("baud_sel11", 32'(eng_baud_decode), 109);
    bus_write(2'd2, 8'hF9);
    check("baud_sel15", 32'(eng_baud_decode), 10417);
    read_check("ctrl_reserved", 2'd2, 'h79);
    bus_write(2'd2, 8'h21);

    // Single character
    send_char(8'hA5, 1'b0, 1'b0, 1'b0);
    read_check("status_one", 2'd1, 'h01);
    read_check("data_a5", 2'd0, 'hA5);
    bus_write(2'd3, 8'h00);
    check("rdata_hold", 32'(rdata), 'hA5);
    read_check("status_drained", 2'd1, 'h00);

    // Interrupt enables and error flags
    bus_write(2'd3, 8'h07);
`ifdef UART_RX_TIMEOUT_EN
    read_check("ie_mask", 2'd3, 'h07);
`else
    read_check("ie_mask", 2'd3, 'h03);
`endif
    bus_write(2'd3, 8'h03);
    check("irq_idle", 32'(irq), 0);
    send_char(8'h3C, 1'b1, 1'b0, 1'b0);
    check("irq_perr", 32'(irq), 1);
    read_check("status_perr", 2'd1, 'h05);
    read_check("data_3c", 2'd0, 'h3C);
    @(negedge clk);
    check("irq_fall", 32'(irq), 0);

    send_char(8'h11, 1'b0, 1'b1, 1'b0);
    read_check("status_ferr", 2'd1, 'h09);
    read_check("data_11", 2'd0, 'h11);

    send_char(8'h22, 1'b0, 1'b0, 1'b1);
    read_check("status_engovf", 2'd1, 'h11);
    read_check("status_engovf_clr", 2'd1, 'h01);
    read_check("data_22", 2'd0, 'h22);

    // FIFO overrun: nine pushes into eight entries
    for (int i = 0; i < 9; i++) send_char(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    read_check("status_ovr", 2'd1, 'h23);
    read_check("status_ovr_clr", 2'd1, 'h03);
    for (int i = 0; i < 8; i++) read_check("data_order", 2'd0, 32'(8'h10 + i));
    read_check("status_after_drain", 2'd1, 'h00);
    read_check("data_empty_again", 2'd0, 'h00);

    // CTRL write flushes
    send_char(8'h55, 1'b0, 1'b0, 1'b1);
    send_char(8'h66, 1'b0, 1'b0, 1'b0);
    bus_write(2'd2, 8'h21);
    read_check("status_flushed", 2'd1, 'h00);

`ifdef UART_RX_TIMEOUT_EN
    // Receive timeout at 32 bit-times of 109 clocks
    bus_write(2'd2, 8'h59);
    bus_write(2'd3, 8'h04);
    send_char(8'h77, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!irq && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_window", 32'((n >= 3378) && (n <= 3596)), 1);
    read_check("status_timeout", 2'd1, 'h41);
    read_check("data_77", 2'd0, 'h77);
    read_check("status_timeout_clr", 2'd1, 'h00);
    bus_write(2'd2, 8'h21);
`endif

    // Reset in the middle of a drain
    bus_write(2'd3, 8'h03);
    send_char(8'h5A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("irq_before_reset", 32'(irq), 1);
    read_check("ctrl_before_reset", 2'd2, 'h21);
    eng_rdata = 8'h66; eng_rx_rdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (eng_reads) seen = 1'b1;
    end
    check("reads_before_reset", 32'(eng_reads), 1);
    #1 rst = 1'b1;
    #1;
    check("async_reads_drop", 32'(eng_reads), 0);
    check("async_irq_drop", 32'(irq), 0);
    check("async_rdata_clr", 32'(rdata), 0);
    eng_rx_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    read_check("post_rst_status", 2'd1, 'h00);
    read_check("post_rst_ie", 2'd3, 'h00);
    read_check("post_rst_ctrl", 2'd2, 'h21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Bus-facing controller for the UART receive engine.
- Holds the frame/baud configuration and drives the engine's BAUD_DECODE, EIGHT, PEN and OHEL inputs.
- Drains each received character from the engine by pulsing its READS strobe, and pushes data plus error flags into a local FIFO.
- Exposes data, status, control and interrupt-enable registers to the CPU bus, and raises an interrupt.

Parameters:
FIFO_DEPTH, 8, number of entries; power of two, minimum 2.
CLK_HZ, 100000000, system clock; fixes the baud table values.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cs  in  1  bus select, one-cycle access
we  in  1  1 = write, 0 = read
addr  in  2  register address
wdata  in  8  write data
rdata  out  8  read data, registered
irq  out  1  interrupt, level
eng_baud_decode  out  19  clocks per bit, to engine
eng_eight  out  1  8-bit data when 1
eng_pen  out  1  parity enable
eng_ohel  out  1  odd parity when 1
eng_reads  out  1  one-cycle acknowledge to engine
eng_rdata  in  8  engine received byte
eng_rx_rdy  in  1  engine character ready
eng_perr  in  1  engine parity error (sticky until READS)
eng_ferr  in  1  engine framing error (sticky until READS)
eng_ovf  in  1  engine overflow (sticky until READS)

Behaviour:
- Reset values:
  - rdata=0, irq=0, eng_reads=0.
  - CTRL: EIGHT=1, PEN=0, OHEL=0, BAUD_SEL=4, giving eng_baud_decode=10417.
  - IE=0, FIFO empty, sticky flags 0, FSM in IDLE.
- Register map:
  - addr 0 DATA (read): returns the head byte and pops. If the FIFO is empty, returns 0x00 with no pointer change.
  - addr 1 STATUS (read):
    - [0] not_empty
    - [1] full
    - [2] head PERR
    - [3] head FERR
    - [4] ENG_OVF sticky
    - [5] FIFO_OVR sticky
    - [6] timeout (see Optional Feature)
    - [7] 0
    - A STATUS read returns the current value, then clears [4] and [5] the same edge.
  - addr 2 CTRL (read/write): [0] EIGHT, [1] PEN, [2] OHEL, [6:3] BAUD_SEL, [7] reserved, reads 0.
    - A write takes effect on the next cycle.
    - A write flushes the FIFO and clears sticky flags.
  - addr 3 IE (read/write): [0] data available, [1] error, [2] timeout.
- eng_baud_decode is a combinational table lookup of BAUD_SEL (values at 100 MHz):
  - 0:333333, 1:83333, 2:41667, 3:20833, 4:10417, 5:5208
  - 6:2604, 7:1736, 8:868, 9:434, 10:217, 11:109
  - 12-15 map to 10417.
- rdata is valid the cycle after cs&~we, then holds until the next read.
- Drain FSM:
  - IDLE: eng_rx_rdy=1 -> DRAIN.
  - DRAIN (one cycle):
    - eng_reads=1.
    - push {eng_ferr, eng_perr, eng_rdata}; a 10-bit entry.
    - eng_ovf=1 sets ENG_OVF sticky.
    - -> WAIT.
  - WAIT: eng_reads=0; stay until eng_rx_rdy=0, then -> IDLE. This guarantees exactly one push per character.
- FIFO boundaries:
  - Push while full with no pop: entry dropped, FIFO_OVR set, existing contents unchanged.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: pop returns 0x00, push lands, count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH. The count is log2(DEPTH)+1 bits wide.
- Simultaneous events:
  - CTRL write concurrent with DRAIN: the flush wins and the pushed entry is discarded.
  - STATUS read on the same edge a sticky bit sets: the set wins.
- irq = (IE[0]&not_empty) | (IE[1]&(ENG_OVF|FIFO_OVR|head PERR|head FERR)) | (IE[2]&timeout). It is registered.
- Reset mid-operation returns everything to reset values immediately. eng_reads drops asynchronously.

Optional Feature:
Macro UART_RX_TIMEOUT_EN.
- With the macro:
  - A bit-time prescaler counts eng_baud_decode clocks.
  - A 6-bit counter counts bit-times while the FIFO is non-empty and no push or pop occurs.
  - At 32 bit-times, STATUS[6] is set.
  - Any push, pop, flush or empty FIFO clears the counters and STATUS[6].
- Without the macro: STATUS[6] and IE[2] read 0, and no counter logic is present.

Decomposition:
- Package uart_pkg:
  - register address constants
  - STATUS/CTRL/IE bit indices
  - FSM state enum {IDLE, DRAIN, WAIT}
  - baud table function sel->19-bit decode
  - FIFO entry width constant (10)
- Sub-module uart_rx_fifo: synchronous FIFO with push, pop, flush, full, empty and head output.

Test Plan:
- Reset, then read CTRL and STATUS -> 0x21 and 0x00; eng_baud_decode=10417; irq=0.
- Write CTRL=0x47 (BAUD_SEL 8, OHEL, PEN, EIGHT) -> next cycle eng_baud_decode=868 with all three engine bits set.
- Engine presents 0xA5 with rx_rdy -> eng_reads pulses exactly once. Then STATUS=0x01 and DATA read=0xA5, after which STATUS=0x00.
- With IE=0x03, push an entry with eng_perr=1:
  - irq rises.
  - STATUS=0x05.
  - After the DATA read, irq falls.
- Push 9 characters at DEPTH=8 -> STATUS=0x23. A STATUS read clears bit 5, and the first 8 bytes read back in order.
- UART_RX_TIMEOUT_EN, BAUD_SEL 11: one byte, then idle -> STATUS[6]=1 after 32×109 clocks (±1 bit-time); a DATA read clears it.
